rs_latch_driver: RTL and testbench

Synchronous sequencer that drives the active-low set/reset inputs of the NAND RS latch from clocked logic. It accepts set/reset requests over a valid/ready handshake and generates clean, non-overlapping active-low pulses of programmed width. It then samples the latch outputs back through a synchronizer and reports whether the latch reached the commanded state. It sits between the synchronous control fabric and any asynchronous NAND-latch cell in the design.

---
 rtl/rs_latch_driver.sv | 118 +++++++++++
 tb/tb_rs_latch_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rs_latch_driver.sv
// Clocked sequencer for an asynchronous NAND RS latch: issues one non-overlapping
// active-low set/reset pulse per request, then verifies the synchronized feedback.
module rs_latch_driver #(
   parameter int PULSE_W = 4,
   parameter int SETTLE  = 2,
   parameter int GAP_W   = 2,
   parameter int CNT_W   = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             req_valid_in,
   input  logic             req_set_in,
   output logic             req_ready_out,
   output logic             s_n_out,
   output logic             r_n_out,
   input  logic             q_in,
   input  logic             qbar_in,
   output logic             done_out,
   output logic             err_out,
   output logic             fault_out,
   output logic [CNT_W-1:0] err_cnt_out
);

   localparam int MAXD = (PULSE_W > SETTLE) ? ((PULSE_W > GAP_W) ? PULSE_W : GAP_W)
                                            : ((SETTLE > GAP_W) ? SETTLE : GAP_W);
   localparam int TW = (MAXD > 1) ? $clog2(MAXD) : 1;
   localparam logic [TW-1:0]    TMR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_SETTLE, S_GAP} state_t;

   state_t           state_q;
   logic [TW-1:0]    tmr_q;
   logic             cmd_q;
   logic             s_n_q, r_n_q;
   logic             done_q, err_q, fault_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic             q_s1_q, q_s2_q, qb_s1_q, qb_s2_q;
   logic             chk_err_d;

   // Anything other than the exact commanded complementary pair is a failure.
   assign chk_err_d = !((q_s2_q == cmd_q) && (qb_s2_q == !cmd_q));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         tmr_q     <= '0;
         cmd_q     <= 1'b0;
         s_n_q     <= 1'b1;
         r_n_q     <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         fault_q   <= 1'b0;
         err_cnt_q <= '0;
         q_s1_q    <= 1'b0;
         q_s2_q    <= 1'b0;
         qb_s1_q   <= 1'b0;
         qb_s2_q   <= 1'b0;
      end else begin
         q_s1_q  <= q_in;
         q_s2_q  <= q_s1_q;
         qb_s1_q <= qbar_in;
         qb_s2_q <= qb_s1_q;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid_in) begin
                  // Exactly one of the two pulse lines goes low, so overlap is impossible.
                  cmd_q   <= req_set_in;
                  s_n_q   <= !req_set_in;
                  r_n_q   <= req_set_in;
                  tmr_q   <= TW'(PULSE_W - 1);
                  state_q <= S_PULSE;
               end
            end
            S_PULSE: begin
               if (tmr_q == '0) begin
                  s_n_q   <= 1'b1;
                  r_n_q   <= 1'b1;
                  tmr_q   <= TW'(SETTLE - 1);
                  state_q <= S_SETTLE;
               end else begin
                  tmr_q <= tmr_q - TMR_ONE;
               end
            end
            S_SETTLE: begin
               if (tmr_q == '0) begin
                  done_q <= 1'b1;
                  err_q  <= chk_err_d;
                  if (chk_err_d) begin
                     fault_q <= 1'b1;
                     if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_ONE;
                  end
                  tmr_q   <= TW'(GAP_W - 1);
                  state_q <= S_GAP;
               end else begin
                  tmr_q <= tmr_q - TMR_ONE;
               end
            end
            S_GAP: begin
               if (tmr_q == '0) state_q <= S_IDLE;
               else             tmr_q   <= tmr_q - TMR_ONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready_out = (state_q == S_IDLE) && !rst_in;
   assign s_n_out       = s_n_q;
   assign r_n_out       = r_n_q;
   assign done_out      = done_q;
   assign err_out       = err_q;
   assign fault_out     = fault_q;
   assign err_cnt_out   = err_cnt_q;

endmodule

// File: tb/tb_rs_latch_driver.sv
// Scoreboard bench for rs_latch_driver: stimulus pushes expected completions,
// a per-cycle monitor checks pulses, ready, done/err, fault and the error counter.
module tb_rs_latch_driver;

   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b1;
   logic             req_valid_in = 1'b0;
   logic             req_set_in = 1'b0;
   logic             req_ready_out, s_n_out, r_n_out;
   logic             q_in, qbar_in;
   logic             done_out, err_out, fault_out;
   logic [CNT_W-1:0] err_cnt_out;

   rs_latch_driver #(.PULSE_W(4), .SETTLE(2), .GAP_W(2), .CNT_W(CNT_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in),
      .req_set_in(req_set_in), .req_ready_out(req_ready_out),
      .s_n_out(s_n_out), .r_n_out(r_n_out), .q_in(q_in), .qbar_in(qbar_in),
      .done_out(done_out), .err_out(err_out), .fault_out(fault_out),
      .err_cnt_out(err_cnt_out));

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      int acc;
      bit cmd;
      bit err;
      int cnt;
      bit fault;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0, failures = 0;
   int   last_acc = -100;
   int   mcnt = 0;
   bit   mfault = 1'b0;
   int   mode = 0;
   bit   mon_en = 1'b0;
   logic lq = 1'b0;

   // Latch model: 0 = follows pulses, 1 = stuck q=0/qbar=1, 2 = invalid q=qbar=1.
   always @(s_n_out or r_n_out) begin
      if (s_n_out === 1'b0)      lq = 1'b1;
      else if (r_n_out === 1'b0) lq = 1'b0;
   end
   assign q_in    = (mode == 0) ? lq  : (mode == 2);
   assign qbar_in = (mode == 0) ? !lq : 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_in = 1'b1;
      req_valid_in = 1'b0;
      last_acc = -100;
      mcnt = 0;
      mfault = 1'b0;
      repeat (n) tick();
      rst_in = 1'b0;
   endtask

   // Holds valid until the model says the DUT is ready, then records the accept.
   task automatic do_req(input bit set, input bit e, input bit hold);
      bit   got;
      exp_t x;
      got = 1'b0;
      req_valid_in = 1'b1;
      req_set_in   = set;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk_in);
         #1;
         if (!rst_in && cyc >= last_acc + 9) begin
            if (e) begin
               mfault = 1'b1;
               if (mcnt < CMAX) mcnt++;
            end
            x.acc = cyc; x.cmd = set; x.err = e; x.cnt = mcnt; x.fault = mfault;
            sbq.push_back(x);
            last_acc = cyc;
            got = 1'b1;
         end
         tick();
      end
      if (!got) begin
         failures++;
         $display("FAIL accept_timeout cyc=%0d actual=no_accept required=accept", cyc);
      end
      if (!hold) req_valid_in = 1'b0;
   endtask

   initial begin : monitor
      bit   prev_rst;
      bit   has, pulse, exp_done;
      int   shown_cnt;
      bit   shown_fault;
      exp_t f;
      prev_rst = 1'b0;
      shown_cnt = 0;
      shown_fault = 1'b0;
      forever begin
         @(negedge clk_in);
         if (mon_en) begin
            if (prev_rst) begin
               sbq.delete();
               shown_cnt = 0;
               shown_fault = 1'b0;
            end
            has = (sbq.size() > 0);
            f.acc = -100; f.cmd = 1'b0; f.err = 1'b0; f.cnt = 0; f.fault = 1'b0;
            if (has) f = sbq[0];
            pulse = has && (cyc >= f.acc + 1) && (cyc <= f.acc + 4);
            chk("s_n", s_n_out, !(pulse && f.cmd));
            chk("r_n", r_n_out, !(pulse && !f.cmd));
            chk("no_overlap", s_n_out | r_n_out, 1);
            chk("ready", req_ready_out, !rst_in && (cyc >= last_acc + 9));
            exp_done = has && (cyc == f.acc + 7);
            chk("done", done_out, exp_done);
            if (exp_done) begin
               chk("err", err_out, f.err);
               shown_cnt = f.cnt;
               shown_fault = f.fault;
               void'(sbq.pop_front());
            end else begin
               chk("err_idle", err_out, 0);
            end
            chk("fault", fault_out, shown_fault);
            chk("err_cnt", err_cnt_out, shown_cnt);
         end
         prev_rst = rst_in;
      end
   end

   initial begin : stim
      tick();
      mon_en = 1'b1;
      do_reset(2);

      // single set with a healthy latch
      do_req(1'b1, 1'b0, 1'b0);
      repeat (12) tick();

      // alternating stream with valid held high
      do_req(1'b1, 1'b0, 1'b1);
      do_req(1'b0, 1'b0, 1'b1);
      do_req(1'b1, 1'b0, 1'b0);
      repeat (12) tick();

      // stuck latch: set fails, reset happens to match
      mode = 1;
      repeat (3) tick();
      do_req(1'b1, 1'b1, 1'b0);
      do_req(1'b0, 1'b0, 1'b0);
      repeat (12) tick();

      // invalid feedback, counter saturates at 3
      do_reset(2);
      mode = 2;
      repeat (3) tick();
      for (int i = 0; i < 5; i++) do_req(i[0], 1'b1, 1'b0);
      repeat (12) tick();

      // reset during second pulse cycle drops the request and clears status
      mode = 0;
      repeat (3) tick();
      do_req(1'b1, 1'b0, 1'b0);
      tick();
      do_reset(1);
      repeat (2) tick();
      do_req(1'b0, 1'b0, 1'b0);
      repeat (12) tick();

      // valid toggled while busy is ignored
      do_req(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         req_valid_in = i[0];
         req_set_in   = ~i[1];
         tick();
      end
      req_valid_in = 1'b0;
      repeat (4) tick();

      // valid held from cycle 3 is accepted when ready returns
      do_req(1'b0, 1'b0, 1'b0);
      tick();
      do_req(1'b1, 1'b0, 1'b0);
      repeat (12) tick();

      chk("sb_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
